// File: rtl/main_mem_ctrl_pkg.sv
// Shared types and constants for the cache-facing main memory controller.
package main_mem_ctrl_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b11
  } state_e;

  typedef enum logic {
    PORT_DATA = 1'b0,
    PORT_INST = 1'b1
  } port_e;

endpackage

// File: rtl/main_mem_ctrl_byte_ram.sv
// Byte-addressed RAM with 4-byte big-endian word access; byte addresses wrap.
module byte_ram
  import main_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  localparam int unsigned AW       = $clog2(MEM_BYTES)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [MEM_BYTES];

  // AW-bit address arithmetic gives the modulo-MEM_BYTES wrap for free.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
        mem_q[addr_i + AW'(k)] <= wdata_i[WORD_W-1-BYTE_W*k -: BYTE_W];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      rdata_o[WORD_W-1-BYTE_W*k -: BYTE_W] = mem_q[addr_i + AW'(k)];
    end
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Arbitrates the data and instruction cache ports onto one byte RAM,
// serving one fixed-latency transaction at a time.
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] dataAddress,
  input  logic              dataRead,
  input  logic              dataWrite,
  input  logic [WORD_W-1:0] dataValue,
  output logic              dataUsingRAM,
  input  logic [WORD_W-1:0] instAddress,
  input  logic              instRead,
  output logic              instUsingRAM,
  output logic [WORD_W-1:0] outRAM,
  output logic              ramReady
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  port_e             last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              data_use_q, data_use_d;
  logic              inst_use_q, inst_use_d;
  logic              ready_q, ready_d;
  logic [WORD_W-1:0] out_q, out_d;

  logic              data_req, inst_req, grant_data;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic              addr_hi_unused;

  assign addr_hi_unused = ^{dataAddress[WORD_W-1:AW], instAddress[WORD_W-1:AW]};

  assign data_req   = dataRead | dataWrite;
  assign inst_req   = instRead;
  assign grant_data = data_req && (!inst_req || (last_q == PORT_INST));

  // Reset in the commit cycle must abort the write.
  assign ram_we = (state_q == BUSY) && (cnt_q == '0) && wr_q && !reset;

  byte_ram #(
    .MEM_BYTES (MEM_BYTES)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    data_use_d = data_use_q;
    inst_use_d = inst_use_q;
    ready_d    = ready_q;
    out_d      = out_q;

    case (state_q)
      IDLE: begin
        if (data_req || inst_req) begin
          addr_d     = grant_data ? dataAddress[AW-1:0] : instAddress[AW-1:0];
          wr_d       = grant_data && dataWrite;
          wdata_d    = dataValue;
          data_use_d = grant_data;
          inst_use_d = !grant_data;
          last_d     = grant_data ? PORT_DATA : PORT_INST;
          cnt_d      = CNT_INIT;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!wr_q) begin
            out_d = ram_rdata;
          end
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready_d    = 1'b0;
        data_use_d = 1'b0;
        inst_use_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= PORT_INST;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      data_use_q <= 1'b0;
      inst_use_q <= 1'b0;
      ready_q    <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      data_use_q <= data_use_d;
      inst_use_q <= inst_use_d;
      ready_q    <= ready_d;
      out_q      <= out_d;
    end
  end

  assign dataUsingRAM = data_use_q;
  assign instUsingRAM = inst_use_q;
  assign ramReady     = ready_q;
  assign outRAM       = out_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-array model.
module tb_main_mem_ctrl;

  localparam int unsigned MEMB = 1024;
  localparam int unsigned LAT  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dataAddress, dataValue, instAddress;
  logic        dataRead, dataWrite, instRead;
  logic        dataUsingRAM, instUsingRAM, ramReady;
  logic [31:0] outRAM;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [MEMB];
  logic        last_inst;
  logic [31:0] exp_out;

  main_mem_ctrl #(
    .MEM_BYTES (MEMB),
    .LATENCY   (LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .dataAddress  (dataAddress),
    .dataRead     (dataRead),
    .dataWrite    (dataWrite),
    .dataValue    (dataValue),
    .dataUsingRAM (dataUsingRAM),
    .instAddress  (instAddress),
    .instRead     (instRead),
    .instUsingRAM (instUsingRAM),
    .outRAM       (outRAM),
    .ramReady     (ramReady)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] addr);
    int unsigned a;
    a = addr % MEMB;
    return {mem[a], mem[(a + 1) % MEMB], mem[(a + 2) % MEMB], mem[(a + 3) % MEMB]};
  endfunction

  task automatic mwrite(input logic [31:0] addr, input logic [31:0] v);
    int unsigned a;
    a = addr % MEMB;
    mem[a]              = v[31:24];
    mem[(a + 1) % MEMB] = v[23:16];
    mem[(a + 2) % MEMB] = v[15:8];
    mem[(a + 3) % MEMB] = v[7:0];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dUse"}, {31'd0, dataUsingRAM}, 32'd0);
    check({tag, "_iUse"}, {31'd0, instUsingRAM}, 32'd0);
    check({tag, "_rdy"},  {31'd0, ramReady},     32'd0);
    check({tag, "_out"},  outRAM,                exp_out);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    dataRead = 1'b0; dataWrite = 1'b0; instRead = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b0;
    exp_out   = '0;
    last_inst = 1'b1;
  endtask

  // One full transaction; requests held until ramReady, inputs scrambled while busy.
  task automatic txn(input logic dr, input logic dw, input logic ir,
                     input logic [31:0] da, input logic [31:0] dv, input logic [31:0] ia);
    logic        win_data, wr;
    logic [31:0] a, v;
    win_data = (dr | dw) && (!ir || last_inst);
    wr       = win_data && dw;
    a        = win_data ? da : ia;
    v        = dv;
    @(negedge clock);
    dataRead = dr; dataWrite = dw; instRead = ir;
    dataAddress = da; dataValue = dv; instAddress = ia;
    @(posedge clock); #1;
    check("grant_data", {31'd0, dataUsingRAM}, {31'd0, win_data});
    check("grant_inst", {31'd0, instUsingRAM}, {31'd0, !win_data});
    check("rdy_accept", {31'd0, ramReady}, 32'd0);
    last_inst = !win_data;
    @(negedge clock);
    dataAddress = $urandom; dataValue = $urandom; instAddress = $urandom;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(posedge clock); #1;
      if (k == int'(LAT)) begin
        if (wr) mwrite(a, v);
        else    exp_out = mread(a);
      end
      check("rdy_busy", {31'd0, ramReady}, (k == int'(LAT)) ? 32'd1 : 32'd0);
      check("use_busy", {30'd0, dataUsingRAM, instUsingRAM}, win_data ? 32'd2 : 32'd1);
      check("out_busy", outRAM, exp_out);
    end
    @(negedge clock);
    dataRead = 1'b0; dataWrite = 1'b0; instRead = 1'b0;
    @(posedge clock); #1;
    check_idle("post");
  endtask

  task automatic reset_mid_write(input logic [31:0] da, input logic [31:0] dv);
    @(negedge clock);
    dataRead = 1'b0; dataWrite = 1'b1; instRead = 1'b0;
    dataAddress = da; dataValue = dv;
    @(posedge clock); #1;
    check("mid_grant", {31'd0, dataUsingRAM}, 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    dataWrite = 1'b0;
    @(posedge clock); #1;
    exp_out   = '0;
    last_inst = 1'b1;
    check_idle("mid_rst");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_idle("mid_after");
  endtask

  initial begin
    logic [31:0] prior, v, base;
    logic        dr, dw, ir;
    reset = 1'b1;
    dataRead = 1'b0; dataWrite = 1'b0; instRead = 1'b0;
    dataAddress = '0; dataValue = '0; instAddress = '0;
    exp_out = '0; last_inst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset");
    @(negedge clock);
    reset = 1'b0;

    // Fill every byte so the model is fully known.
    for (int unsigned w = 0; w < MEMB / 4; w++) begin
      txn(1'b0, 1'b1, 1'b0, w * 4, $urandom, 32'd0);
    end

    do_reset();
    #1;
    check_idle("reset2");

    // Ties after reset: data, then inst, then data.
    txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4);
    txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4);
    txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4);

    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10);
    check("inst_rd_10", outRAM, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 1'b0, 32'h3FE, 32'h11223344, 32'h0);
    txn(1'b1, 1'b0, 1'b0, 32'h3FE, 32'h0, 32'h0);
    check("wrap_rd", outRAM, 32'h11223344);
    txn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("wrap_lo", {16'd0, outRAM[31:16]}, 32'h3344);

    v = $urandom;
    txn(1'b0, 1'b1, 1'b0, 32'h410, v, 32'h0);
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10);
    check("alias_rd", outRAM, v);

    prior = mread(32'h20);
    reset_mid_write(32'h20, 32'hCAFEBABE);
    txn(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0);
    check("abort_rd", outRAM, prior);

    base = outRAM;
    txn(1'b1, 1'b1, 1'b0, 32'h8, 32'h01020304, 32'h0);
    check("rw_keep", outRAM, base);
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8);
    check("rw_rd", outRAM, 32'h01020304);

    for (int i = 0; i < 60; i++) begin
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      ir = 1'($urandom_range(0, 1));
      if (!(dr | dw | ir)) ir = 1'b1;
      txn(dr, dw, ir, $urandom, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Memory-side responder for the cache-to-RAM handshake (addressToRAM/readRAM/writeRAM/valueRAM out, outRAM/ramReady/dataUsingRAM back).
- Arbitrates one shared byte-addressed main memory between the data-cache port and the instruction-cache port.
- Serves one transaction at a time with a fixed, parameterised access latency.
- Returns the per-port grant ("UsingRAM") and ready strobes the caches wait on.

Parameters:
- MEM_BYTES, 1024, main memory size in bytes (power of two).
- LATENCY, 4, cycles from grant to ready (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dataAddress  in  32  byte address from data cache
- dataRead  in  1  data-cache read request (level)
- dataWrite  in  1  data-cache write-back request (level)
- dataValue  in  32  write-back word, big-endian
- dataUsingRAM  out  1  data port owns memory
- instAddress  in  32  byte address from instruction cache
- instRead  in  1  instruction-cache read request (level)
- instUsingRAM  out  1  instruction port owns memory
- outRAM  out  32  read word, big-endian, shared by both ports
- ramReady  out  1  one-cycle completion strobe

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on the rising edge of clock.
- Reset values:
  - dataUsingRAM=0, instUsingRAM=0, ramReady=0, outRAM=0.
  - State=IDLE, lastGrant=INST.
  - Memory array is NOT cleared.
- States: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request arbitration:
  - Data request = dataRead|dataWrite; inst request = instRead.
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to lastGrant wins (round-robin). The first tie after reset goes to data.
- IDLE, on accept:
  - Latch address, op and write word. If dataRead and dataWrite are both high, the op is write.
  - Assert the winner's UsingRAM, update lastGrant, load cnt=LATENCY-1, go to BUSY.
- BUSY:
  - cnt≠0: decrement.
  - cnt==0, read: outRAM <= {m[a],m[a+1],m[a+2],m[a+3]}.
  - cnt==0, write: m[a..a+3] <= dataValue[31:24], [23:16], [15:8], [7:0].
  - cnt==0: ramReady<=1, go to DONE.
- DONE:
  - ramReady and UsingRAM are high together for exactly this cycle.
  - Next edge: both drop to 0, go to IDLE.
- Latency: UsingRAM is visible the cycle after accept; ramReady is visible LATENCY cycles after UsingRAM first rises.
- Request inputs are ignored outside IDLE; input changes during BUSY have no effect.
- outRAM holds its last read value until the next read completes. Writes do not alter outRAM.
- Addressing:
  - Byte index a = address mod MEM_BYTES.
  - a+1..a+3 wrap modulo MEM_BYTES.
  - Unaligned addresses are legal.
- A request still high in the IDLE cycle after DONE is treated as a new transaction. Caches must drop their request on sampling ramReady, or on UsingRAM for writes.
- Reset during BUSY/DONE:
  - Transaction is aborted; a pending write is not committed.
  - Outputs return to reset values.
  - Bytes committed by earlier writes persist.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b11.
  - Port id constants: PORT_DATA=0, PORT_INST=1.
  - Word and byte width constants.
- One sub-module, byte_ram:
  - MEM_BYTES×8 array.
  - Synchronous 4-byte big-endian write.
  - Combinational 4-byte big-endian read with modulo wrap.

Test Plan:
- Basic write/read, LATENCY=4:
  - Data write 0x00000010 with dataValue=0xDEADBEEF → dataUsingRAM high 5 cycles, ramReady pulses on the 5th; bytes m[16..19]=DE,AD,BE,EF.
  - Then instRead at 0x10 → instUsingRAM, then outRAM=0xDEADBEEF with ramReady.
- Simultaneous requests after reset, dataRead@0x0 and instRead@0x4 → data served first; inst served next; the next tie goes to data.
- Wrap-around: write 0x11223344 to address 0x3FE (MEM_BYTES=1024) → m[1022]=11, m[1023]=22, m[0]=33, m[1]=44; read 0x3FE returns 0x11223344.
- Address aliasing: write to 0x00000410 → aliases 0x10; read 0x10 returns the written word.
- Reset mid-op: assert reset two cycles into a write of 0xCAFEBABE @0x20 → grant/ready 0, state IDLE; a read of 0x20 returns the prior contents, not 0xCAFEBABE.
- Read and write both high on the data port, value 0x01020304 @0x8 → treated as a write; outRAM unchanged; a later read returns 0x01020304.
